// File: rtl/id_stage_pipe_if.sv
// Signal bundle for the RV32IM decode stage: IF/ID slot, WB write port, EX flush
// and the registered ID/EX boundary.
interface id_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
);
  logic              IF_VALID;
  logic [XLEN-1:0]   IF_PC;
  logic [XLEN-1:0]   IF_PC_PLUS4;
  logic [31:0]       IF_INSTRUCTION;
  logic              WB_WRITE_ENABLE;
  logic [RIDX_W-1:0] WB_RD;
  logic [XLEN-1:0]   WB_WRITE_DATA;
  logic              EX_FLUSH;

  logic              ID_STALL;
  logic              ID_VALID;
  logic [XLEN-1:0]   ID_PC;
  logic [XLEN-1:0]   ID_PC_PLUS4;
  logic [XLEN-1:0]   ID_READ_DATA1;
  logic [XLEN-1:0]   ID_READ_DATA2;
  logic [RIDX_W-1:0] ID_RS1;
  logic [RIDX_W-1:0] ID_RS2;
  logic [RIDX_W-1:0] ID_RD;
  logic [XLEN-1:0]   ID_IMMEDIATE;
  logic [2:0]        ID_FUNC3;
  logic              ID_FUNC7_5;
  logic              ID_MUL;
  logic              ID_WRITE_ENABLE;
  logic              ID_MEM_READ;
  logic              ID_MEM_WRITE;
  logic              ID_BRANCH;
  logic              ID_JUMP;
  logic              ID_IMM_SELECT;
  logic              ID_PC_SELECT;
  logic              ID_ILLEGAL;

  modport master (
    output IF_VALID, IF_PC, IF_PC_PLUS4, IF_INSTRUCTION,
           WB_WRITE_ENABLE, WB_RD, WB_WRITE_DATA, EX_FLUSH,
    input  ID_STALL, ID_VALID, ID_PC, ID_PC_PLUS4, ID_READ_DATA1, ID_READ_DATA2,
           ID_RS1, ID_RS2, ID_RD, ID_IMMEDIATE, ID_FUNC3, ID_FUNC7_5, ID_MUL,
           ID_WRITE_ENABLE, ID_MEM_READ, ID_MEM_WRITE, ID_BRANCH, ID_JUMP,
           ID_IMM_SELECT, ID_PC_SELECT, ID_ILLEGAL
  );

  modport slave (
    input  IF_VALID, IF_PC, IF_PC_PLUS4, IF_INSTRUCTION,
           WB_WRITE_ENABLE, WB_RD, WB_WRITE_DATA, EX_FLUSH,
    output ID_STALL, ID_VALID, ID_PC, ID_PC_PLUS4, ID_READ_DATA1, ID_READ_DATA2,
           ID_RS1, ID_RS2, ID_RD, ID_IMMEDIATE, ID_FUNC3, ID_FUNC7_5, ID_MUL,
           ID_WRITE_ENABLE, ID_MEM_READ, ID_MEM_WRITE, ID_BRANCH, ID_JUMP,
           ID_IMM_SELECT, ID_PC_SELECT, ID_ILLEGAL
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32IM/RV32E decode stage: register file with WB bypass, immediate/control decode,
// load-use stall, flush and a one-cycle ID/EX register.
module id_stage_pipe #(
  parameter int          XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int          RIDX_W    = 5
) (
  input logic            CLK,
  input logic            RST,
  id_stage_pipe_if.slave bus
);
  localparam int RB = $clog2(REG_COUNT);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic write_enable;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic imm_select;
    logic pc_select;
    logic mul;
  } ctrl_t;

  function automatic logic in_range(input logic [RIDX_W-1:0] idx);
    return 32'(idx) < REG_COUNT;
  endfunction

  logic [31:0]       instr;
  opcode_e           opcode;
  logic [RIDX_W-1:0] rs1;
  logic [RIDX_W-1:0] rs2;
  logic [RIDX_W-1:0] rd;

  assign instr  = bus.IF_INSTRUCTION;
  assign opcode = opcode_e'(instr[6:0]);
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  logic [XLEN-1:0] regs [REG_COUNT];
  logic            wb_ok;

  // x0 is never stored, so regs[0] stays at its reset value of zero.
  assign wb_ok = bus.WB_WRITE_ENABLE && (bus.WB_RD != '0) && in_range(bus.WB_RD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs <= '{default: '0};
    end else if (wb_ok) begin
      regs[bus.WB_RD[RB-1:0]] <= bus.WB_WRITE_DATA;
    end
  end

  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != '0 && in_range(rs1)) rdata1 = regs[rs1[RB-1:0]];
    if (rs2 != '0 && in_range(rs2)) rdata2 = regs[rs2[RB-1:0]];
    if (wb_ok && bus.WB_RD == rs1) rdata1 = bus.WB_WRITE_DATA;
    if (wb_ok && bus.WB_RD == rs2) rdata2 = bus.WB_WRITE_DATA;
  end

  ctrl_t       ctrl;
  logic        known;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        illegal;
  logic [31:0] imm32;

  always_comb begin
    ctrl    = '0;
    known   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    case (opcode)
      OP_LUI: begin
        ctrl.write_enable = 1'b1;
        ctrl.imm_select   = 1'b1;
        use_rd            = 1'b1;
        imm32             = {instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctrl.write_enable = 1'b1;
        ctrl.imm_select   = 1'b1;
        ctrl.pc_select    = 1'b1;
        use_rd            = 1'b1;
        imm32             = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        ctrl.write_enable = 1'b1;
        ctrl.jump         = 1'b1;
        ctrl.imm_select   = 1'b1;
        ctrl.pc_select    = 1'b1;
        use_rd            = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.write_enable = 1'b1;
        ctrl.jump         = 1'b1;
        ctrl.imm_select   = 1'b1;
        use_rd            = 1'b1;
        use_rs1           = 1'b1;
        imm32             = {{20{instr[31]}}, instr[31:20]};
      end
      OP_BRANCH: begin
        ctrl.branch    = 1'b1;
        ctrl.pc_select = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LOAD: begin
        ctrl.write_enable = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.imm_select   = 1'b1;
        use_rd            = 1'b1;
        use_rs1           = 1'b1;
        imm32             = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.imm_select = 1'b1;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_IMM: begin
        ctrl.write_enable = 1'b1;
        ctrl.imm_select   = 1'b1;
        use_rd            = 1'b1;
        use_rs1           = 1'b1;
        imm32             = {{20{instr[31]}}, instr[31:20]};
      end
      OP_OP: begin
        ctrl.write_enable = 1'b1;
        ctrl.mul          = (instr[31:25] == 7'b0000001);
        use_rd            = 1'b1;
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
      end
      default: known = 1'b0;
    endcase
    // Only index fields the format actually uses are range-checked; in U/J formats
    // those bit positions carry immediate bits.
    illegal = !known || (use_rd && !in_range(rd)) || (use_rs1 && !in_range(rs1)) ||
              (use_rs2 && !in_range(rs2));
    if (illegal) ctrl = '0;
  end

  logic reads_rs2;
  logic hazard;
  logic bubble;

  assign reads_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign hazard    = bus.ID_VALID && bus.ID_MEM_READ && (bus.ID_RD != '0) && bus.IF_VALID &&
                     ((rs1 == bus.ID_RD) || (reads_rs2 && (rs2 == bus.ID_RD)));
  assign bus.ID_STALL = hazard && !bus.EX_FLUSH;
  assign bubble       = bus.EX_FLUSH || !bus.IF_VALID || hazard;

  // Bubbles clear the whole ID/EX slot, which also guarantees the stall drops next cycle.
  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      bus.ID_VALID        <= 1'b0;
      bus.ID_PC           <= '0;
      bus.ID_PC_PLUS4     <= '0;
      bus.ID_READ_DATA1   <= '0;
      bus.ID_READ_DATA2   <= '0;
      bus.ID_RS1          <= '0;
      bus.ID_RS2          <= '0;
      bus.ID_RD           <= '0;
      bus.ID_IMMEDIATE    <= '0;
      bus.ID_FUNC3        <= '0;
      bus.ID_FUNC7_5      <= 1'b0;
      bus.ID_MUL          <= 1'b0;
      bus.ID_WRITE_ENABLE <= 1'b0;
      bus.ID_MEM_READ     <= 1'b0;
      bus.ID_MEM_WRITE    <= 1'b0;
      bus.ID_BRANCH       <= 1'b0;
      bus.ID_JUMP         <= 1'b0;
      bus.ID_IMM_SELECT   <= 1'b0;
      bus.ID_PC_SELECT    <= 1'b0;
      bus.ID_ILLEGAL      <= 1'b0;
    end else begin
      bus.ID_VALID        <= 1'b1;
      bus.ID_PC           <= bus.IF_PC;
      bus.ID_PC_PLUS4     <= bus.IF_PC_PLUS4;
      bus.ID_READ_DATA1   <= rdata1;
      bus.ID_READ_DATA2   <= rdata2;
      bus.ID_RS1          <= rs1;
      bus.ID_RS2          <= rs2;
      bus.ID_RD           <= rd;
      bus.ID_IMMEDIATE    <= XLEN'($signed(imm32));
      bus.ID_FUNC3        <= instr[14:12];
      bus.ID_FUNC7_5      <= instr[30];
      bus.ID_MUL          <= ctrl.mul;
      bus.ID_WRITE_ENABLE <= ctrl.write_enable;
      bus.ID_MEM_READ     <= ctrl.mem_read;
      bus.ID_MEM_WRITE    <= ctrl.mem_write;
      bus.ID_BRANCH       <= ctrl.branch;
      bus.ID_JUMP         <= ctrl.jump;
      bus.ID_IMM_SELECT   <= ctrl.imm_select;
      bus.ID_PC_SELECT    <= ctrl.pc_select;
      bus.ID_ILLEGAL      <= illegal;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: RV32I and RV32E instances share one stimulus stream and are
// compared every cycle against an instruction-level model, plus hand-computed literals.
module tb_id_stage_pipe;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.XLEN(32), .RIDX_W(5)) bi ();
  id_stage_pipe_if #(.XLEN(32), .RIDX_W(5)) be ();

  assign be.IF_VALID        = bi.IF_VALID;
  assign be.IF_PC           = bi.IF_PC;
  assign be.IF_PC_PLUS4     = bi.IF_PC_PLUS4;
  assign be.IF_INSTRUCTION  = bi.IF_INSTRUCTION;
  assign be.WB_WRITE_ENABLE = bi.WB_WRITE_ENABLE;
  assign be.WB_RD           = bi.WB_RD;
  assign be.WB_WRITE_DATA   = bi.WB_WRITE_DATA;
  assign be.EX_FLUSH        = bi.EX_FLUSH;

  id_stage_pipe #(.XLEN(32), .REG_COUNT(32), .RIDX_W(5)) dut_i (.CLK(CLK), .RST(RST), .bus(bi));
  id_stage_pipe #(.XLEN(32), .REG_COUNT(16), .RIDX_W(5)) dut_e (.CLK(CLK), .RST(RST), .bus(be));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f75, mul, ill, we, mr, mw, br, jp, isel, psel;
  } exp_t;

  int   n_total = 0;
  int   n_pass  = 0;
  bit   armed   = 1'b0;
  exp_t exp_i, exp_e;
  logic [31:0] mreg_i [32];
  logic [31:0] mreg_e [32];
  logic [31:0] pc_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) $display("FAIL %s: got %h expected %h", name, act, want);
    else n_pass++;
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    chk(name, {31'b0, act}, {31'b0, want});
  endtask

  // Instruction-level meaning of a decoded RISC-V word.
  function automatic exp_t decode(input int unsigned rc, input logic [31:0] ins,
                                  input logic [31:0] pc, input logic [31:0] pc4,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t e = '0;
    logic signed [31:0] s = ins;
    bit known = 1, urd = 0, urs1 = 0, urs2 = 0;
    e.valid = 1; e.pc = pc; e.pc4 = pc4; e.rd1 = a; e.rd2 = b;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.f3 = ins[14:12]; e.f75 = ins[30];
    case (ins[6:0])
      7'h37: begin e.we = 1; e.isel = 1; urd = 1; e.imm = ins & 32'hFFFFF000; end
      7'h17: begin e.we = 1; e.isel = 1; e.psel = 1; urd = 1; e.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        e.we = 1; e.jp = 1; e.isel = 1; e.psel = 1; urd = 1;
        e.imm = 32'((s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                (32'(ins[30:21]) << 1);
      end
      7'h67: begin e.we = 1; e.jp = 1; e.isel = 1; urd = 1; urs1 = 1; e.imm = 32'(s >>> 20); end
      7'h63: begin
        e.br = 1; e.psel = 1; urs1 = 1; urs2 = 1;
        e.imm = 32'((s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                (32'(ins[11:8]) << 1);
      end
      7'h03: begin e.we = 1; e.mr = 1; e.isel = 1; urd = 1; urs1 = 1; e.imm = 32'(s >>> 20); end
      7'h23: begin
        e.mw = 1; e.isel = 1; urs1 = 1; urs2 = 1;
        e.imm = 32'((s >>> 25) << 5) | 32'(ins[11:7]);
      end
      7'h13: begin e.we = 1; e.isel = 1; urd = 1; urs1 = 1; e.imm = 32'(s >>> 20); end
      7'h33: begin e.we = 1; urd = 1; urs1 = 1; urs2 = 1; e.mul = (ins[31:25] == 7'd1); end
      default: known = 0;
    endcase
    e.ill = !known || (urd && ins[11:7] >= rc) || (urs1 && ins[19:15] >= rc) ||
            (urs2 && ins[24:20] >= rc);
    if (e.ill) begin
      e.we = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.isel = 0; e.psel = 0; e.mul = 0;
    end
    return e;
  endfunction

  function automatic logic hz(input exp_t cur);
    logic [31:0] ins = bi.IF_INSTRUCTION;
    bit reads2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    return cur.valid && cur.mr && cur.rd != 0 && bi.IF_VALID &&
           (ins[19:15] == cur.rd || (reads2 && ins[24:20] == cur.rd));
  endfunction

  function automatic logic [31:0] rd_model(input int unsigned rc, input logic [31:0] r [32],
                                           input logic [4:0] idx);
    if (idx == 0) return 0;
    if (idx >= rc) return 0;
    if (bi.WB_WRITE_ENABLE && bi.WB_RD == idx) return bi.WB_WRITE_DATA;
    return r[idx];
  endfunction

  function automatic exp_t next_exp(input int unsigned rc, input exp_t cur,
                                    input logic [31:0] r [32]);
    logic [31:0] ins = bi.IF_INSTRUCTION;
    if (RST || bi.EX_FLUSH || !bi.IF_VALID || hz(cur)) return '0;
    return decode(rc, ins, bi.IF_PC, bi.IF_PC_PLUS4,
                  rd_model(rc, r, ins[19:15]), rd_model(rc, r, ins[24:20]));
  endfunction

  always @(posedge CLK) begin
    exp_i <= next_exp(32, exp_i, mreg_i);
    exp_e <= next_exp(16, exp_e, mreg_e);
    if (RST) begin
      armed <= 1'b1;
      for (int k = 0; k < 32; k++) begin
        mreg_i[k] <= '0;
        mreg_e[k] <= '0;
      end
    end else if (bi.WB_WRITE_ENABLE && bi.WB_RD != 0) begin
      mreg_i[bi.WB_RD] <= bi.WB_WRITE_DATA;
      if (bi.WB_RD < 16) mreg_e[bi.WB_RD] <= bi.WB_WRITE_DATA;
    end
  end

  function automatic exp_t grab_i();
    exp_t a;
    a.valid = bi.ID_VALID; a.pc = bi.ID_PC; a.pc4 = bi.ID_PC_PLUS4;
    a.rd1 = bi.ID_READ_DATA1; a.rd2 = bi.ID_READ_DATA2; a.imm = bi.ID_IMMEDIATE;
    a.rs1 = bi.ID_RS1; a.rs2 = bi.ID_RS2; a.rd = bi.ID_RD; a.f3 = bi.ID_FUNC3;
    a.f75 = bi.ID_FUNC7_5; a.mul = bi.ID_MUL; a.ill = bi.ID_ILLEGAL;
    a.we = bi.ID_WRITE_ENABLE; a.mr = bi.ID_MEM_READ; a.mw = bi.ID_MEM_WRITE;
    a.br = bi.ID_BRANCH; a.jp = bi.ID_JUMP; a.isel = bi.ID_IMM_SELECT; a.psel = bi.ID_PC_SELECT;
    return a;
  endfunction

  function automatic exp_t grab_e();
    exp_t a;
    a.valid = be.ID_VALID; a.pc = be.ID_PC; a.pc4 = be.ID_PC_PLUS4;
    a.rd1 = be.ID_READ_DATA1; a.rd2 = be.ID_READ_DATA2; a.imm = be.ID_IMMEDIATE;
    a.rs1 = be.ID_RS1; a.rs2 = be.ID_RS2; a.rd = be.ID_RD; a.f3 = be.ID_FUNC3;
    a.f75 = be.ID_FUNC7_5; a.mul = be.ID_MUL; a.ill = be.ID_ILLEGAL;
    a.we = be.ID_WRITE_ENABLE; a.mr = be.ID_MEM_READ; a.mw = be.ID_MEM_WRITE;
    a.br = be.ID_BRANCH; a.jp = be.ID_JUMP; a.isel = be.ID_IMM_SELECT; a.psel = be.ID_PC_SELECT;
    return a;
  endfunction

  task automatic compare_mode(input string t, input exp_t a, input exp_t w,
                              input logic stall_act, input logic stall_want);
    chk1({t, "stall"}, stall_act, stall_want);
    chk1({t, "valid"}, a.valid, w.valid);
    chk1({t, "we"}, a.we, w.we);
    chk1({t, "mem_read"}, a.mr, w.mr);
    chk1({t, "mem_write"}, a.mw, w.mw);
    chk1({t, "branch"}, a.br, w.br);
    chk1({t, "jump"}, a.jp, w.jp);
    chk1({t, "imm_sel"}, a.isel, w.isel);
    chk1({t, "pc_sel"}, a.psel, w.psel);
    if (w.valid) begin
      chk({t, "pc"}, a.pc, w.pc);
      chk({t, "pc4"}, a.pc4, w.pc4);
      chk({t, "rdata1"}, a.rd1, w.rd1);
      chk({t, "rdata2"}, a.rd2, w.rd2);
      chk({t, "imm"}, a.imm, w.imm);
      chk({t, "idx"}, {17'b0, a.rs1, a.rs2, a.rd}, {17'b0, w.rs1, w.rs2, w.rd});
      chk({t, "func"}, {28'b0, a.f3, a.f75}, {28'b0, w.f3, w.f75});
      chk1({t, "mul"}, a.mul, w.mul);
      chk1({t, "illegal"}, a.ill, w.ill);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      compare_mode("i.", grab_i(), exp_i, bi.ID_STALL, hz(exp_i) && !bi.EX_FLUSH);
      compare_mode("e.", grab_e(), exp_e, be.ID_STALL, hz(exp_e) && !bi.EX_FLUSH);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins);
    bi.IF_VALID = v;
    bi.IF_INSTRUCTION = ins;
    bi.IF_PC = pc_ctr;
    bi.IF_PC_PLUS4 = pc_ctr + 32'd4;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bi.WB_WRITE_ENABLE = 1'b1;
    bi.WB_RD = r;
    bi.WB_WRITE_DATA = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    bi.WB_WRITE_ENABLE = 1'b0;
    bi.EX_FLUSH = 1'b0;
  endtask

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] LW7   = 32'h0000A383;
  localparam logic [31:0] ADD8  = 32'h00738433;

  initial begin
    pc_ctr = 32'h0000_1000;
    RST = 1'b1;
    bi.EX_FLUSH = 1'b0;
    bi.WB_WRITE_ENABLE = 1'b0;
    bi.WB_RD = '0;
    bi.WB_WRITE_DATA = '0;
    drive(1'b1, ADD3);
    wb(5'd4, 32'h0000_DEAD);
    tick();
    chk1("reset_valid", bi.ID_VALID, 1'b0);
    chk1("reset_stall", bi.ID_STALL, 1'b0);
    chk1("reset_we", bi.ID_WRITE_ENABLE, 1'b0);

    drive(1'b0, 32'h0);
    wb(5'd1, 32'h0000_000A);
    tick();
    drive(1'b1, ADD3);
    tick();
    chk("add_rdata1", bi.ID_READ_DATA1, 32'h0000_000A);
    chk("add_rdata2", bi.ID_READ_DATA2, 32'h0);
    chk("add_rd", 32'(bi.ID_RD), 32'd3);
    chk1("add_we", bi.ID_WRITE_ENABLE, 1'b1);
    chk1("add_valid", bi.ID_VALID, 1'b1);

    drive(1'b1, 32'hFFF28313);
    wb(5'd5, 32'h1234_5678);
    tick();
    chk("bypass_rdata1", bi.ID_READ_DATA1, 32'h1234_5678);
    chk("addi_imm", bi.ID_IMMEDIATE, 32'hFFFF_FFFF);
    chk1("addi_imm_sel", bi.ID_IMM_SELECT, 1'b1);

    drive(1'b1, 32'h000204B3);
    tick();
    chk("reset_wb_discarded", bi.ID_READ_DATA1, 32'h0);

    drive(1'b1, 32'h00000533);
    wb(5'd0, 32'h0000_0055);
    tick();
    chk("x0_bypass", bi.ID_READ_DATA1, 32'h0);
    drive(1'b1, 32'h00000533);
    tick();
    chk("x0_after_write", bi.ID_READ_DATA1, 32'h0);

    drive(1'b1, LW7);
    tick();
    chk1("lw_mem_read", bi.ID_MEM_READ, 1'b1);
    drive(1'b1, ADD8);
    #1 chk1("loaduse_stall", bi.ID_STALL, 1'b1);
    tick();
    chk1("loaduse_bubble", bi.ID_VALID, 1'b0);
    chk1("loaduse_stall_once", bi.ID_STALL, 1'b0);
    tick();
    chk1("loaduse_add_valid", bi.ID_VALID, 1'b1);
    chk("loaduse_add_rd", 32'(bi.ID_RD), 32'd8);

    drive(1'b1, LW7);
    tick();
    drive(1'b1, ADD8);
    bi.EX_FLUSH = 1'b1;
    #1 chk1("flush_stall", bi.ID_STALL, 1'b0);
    tick();
    chk1("flush_bubble", bi.ID_VALID, 1'b0);

    drive(1'b1, 32'hFE000CE3);
    tick();
    chk("beq_imm", bi.ID_IMMEDIATE, 32'hFFFF_FFF8);
    chk1("beq_branch", bi.ID_BRANCH, 1'b1);
    chk1("beq_pc_sel", bi.ID_PC_SELECT, 1'b1);
    drive(1'b1, 32'h0010006F);
    tick();
    chk("jal_imm", bi.ID_IMMEDIATE, 32'h0000_0800);
    chk1("jal_jump", bi.ID_JUMP, 1'b1);
    drive(1'b1, 32'hABCDE0B7);
    tick();
    chk("lui_imm", bi.ID_IMMEDIATE, 32'hABCD_E000);
    drive(1'b1, 32'h0050A223);
    tick();
    chk("sw_imm", bi.ID_IMMEDIATE, 32'h0000_0004);
    chk1("sw_mem_write", bi.ID_MEM_WRITE, 1'b1);
    drive(1'b1, 32'h00001117);
    tick();
    chk("auipc_imm", bi.ID_IMMEDIATE, 32'h0000_1000);
    chk1("auipc_pc_sel", bi.ID_PC_SELECT, 1'b1);

    drive(1'b1, 32'h002088B3);
    tick();
    chk1("rv32e_x17_illegal", be.ID_ILLEGAL, 1'b1);
    chk1("rv32e_x17_we", be.ID_WRITE_ENABLE, 1'b0);
    chk1("rv32i_x17_legal", bi.ID_ILLEGAL, 1'b0);
    drive(1'b1, 32'h0000007F);
    tick();
    chk1("op7f_illegal", bi.ID_ILLEGAL, 1'b1);
    chk1("op7f_we", bi.ID_WRITE_ENABLE, 1'b0);
    drive(1'b1, 32'h023100B3);
    tick();
    chk1("mul_flag", bi.ID_MUL, 1'b1);
    chk1("mul_legal", bi.ID_ILLEGAL, 1'b0);

    drive(1'b1, LW7);
    tick();
    drive(1'b1, ADD8);
    RST = 1'b1;
    wb(5'd2, 32'h0000_BEEF);
    tick();
    chk1("rst_during_hazard_valid", bi.ID_VALID, 1'b0);
    chk1("rst_during_hazard_stall", bi.ID_STALL, 1'b0);
    drive(1'b1, ADD3);
    tick();
    chk("rst_clears_x1", bi.ID_READ_DATA1, 32'h0);
    chk("rst_drops_wb_x2", bi.ID_READ_DATA2, 32'h0);

    drive(1'b0, 32'h0);
    tick();
    chk1("invalid_bubble", bi.ID_VALID, 1'b0);
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
